// File: rtl/scaler_ram_pkg.sv
// Shared definitions for the scaler line-buffer RAM port models.
// Write-mode codes, counter width and sizing helpers.
package scaler_ram_pkg;

    localparam int WM_NORMAL      = 0;
    localparam int WM_TRANSPARENT = 1;
    localparam int WM_RBW         = 2;

    localparam int CNT_W = 16;

    typedef logic [CNT_W-1:0] cnt_t;

    function automatic int depth(input int aw);
        return 1 << aw;
    endfunction

    function automatic cnt_t sat_inc(input cnt_t c);
        return (&c) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/scaler_ram_oreg.sv
// Optional read-data output register with output clock enable.
// Shared by the port-A and port-B RAM models.
module scaler_ram_oreg #(
    parameter int DATA_WIDTH = 8,
    parameter int OUTPUT_REG = 0,
    parameter int RD_OCE_EN  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] d,
    input  logic                  oce,
    output logic [DATA_WIDTH-1:0] q
);

    generate
        if (OUTPUT_REG != 0) begin : g_reg
            logic ld;

            assign ld = (RD_OCE_EN == 0) || oce;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q <= '0;
                end else if (ld) begin
                    q <= d;
                end
            end
        end else begin : g_bypass
            logic unused_oreg;

            assign unused_oreg = ^{clk, rst, oce};
            assign q = d;
        end
    endgenerate

endmodule

// File: rtl/scaler_ram_a_resp_model.sv
// Behavioural port-A responder for the scaler line-buffer DPRAM.
// Matches vendor port-A timing and adds access counters plus a protocol flag.
module scaler_ram_a_resp_model
    import scaler_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 8,
    parameter int OUTPUT_REG = 0,
    parameter int RD_OCE_EN  = 0,
    parameter int CLK_EN     = 0,
    parameter int WRITE_MODE = 0,
    parameter int INIT_VAL   = 0
) (
    input  logic                  a_clk,
    input  logic                  tb_a_rst,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wr_data,
    input  logic                  a_wr_en,
    input  logic                  a_clk_en,
    input  logic                  a_addr_strobe,
    input  logic                  a_rd_oce,
    output logic [DATA_WIDTH-1:0] a_rd_data,
    output logic [CNT_W-1:0]      wr_cnt,
    output logic [CNT_W-1:0]      rd_cnt,
    output logic                  proto_err
);

    localparam int DEPTH = depth(ADDR_WIDTH);
    localparam logic [DATA_WIDTH-1:0] INIT_W = DATA_WIDTH'(INIT_VAL);
    localparam logic IS_TRANSP = (WRITE_MODE == WM_TRANSPARENT);
    localparam logic IS_RBW    = (WRITE_MODE == WM_RBW);

    // Contents survive reset; only the time-zero value is defined.
    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: INIT_W};

    logic [DATA_WIDTH-1:0] rd_lat;
    logic [DATA_WIDTH-1:0] lat_nxt;
    logic [ADDR_WIDTH-1:0] addr_lat;
    logic [ADDR_WIDTH-1:0] ea;
    logic                  ce;
    logic                  acc;
    logic                  unk;

    assign ce  = (CLK_EN == 0) || a_clk_en;
    assign acc = ce && !tb_a_rst;
    assign ea  = a_addr_strobe ? addr_lat : a_addr;

    always_comb begin
        unk = 1'b0;
`ifndef SYNTHESIS
        unk = $isunknown({a_addr, a_wr_en});
`endif
    end

    always_comb begin
        lat_nxt = rd_lat;
        unique case (1'b1)
            (!a_wr_en || IS_RBW):     lat_nxt = mem[ea];
            (a_wr_en && IS_TRANSP):   lat_nxt = a_wr_data;
            default:                  lat_nxt = rd_lat;
        endcase
    end

    always_ff @(posedge a_clk) begin
        if (acc && a_wr_en) begin
            mem[ea] <= a_wr_data;
        end
    end

    always_ff @(posedge a_clk or posedge tb_a_rst) begin
        if (tb_a_rst) begin
            rd_lat    <= '0;
            addr_lat  <= '0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            proto_err <= 1'b0;
        end else if (ce) begin
            addr_lat <= ea;
            rd_lat   <= lat_nxt;
            if (unk) begin
                proto_err <= 1'b1;
            end
            if (a_wr_en) begin
                wr_cnt <= sat_inc(wr_cnt);
            end else begin
                rd_cnt <= sat_inc(rd_cnt);
            end
        end
    end

    scaler_ram_oreg #(
        .DATA_WIDTH (DATA_WIDTH),
        .OUTPUT_REG (OUTPUT_REG),
        .RD_OCE_EN  (RD_OCE_EN)
    ) u_oreg (
        .clk (a_clk),
        .rst (tb_a_rst),
        .d   (rd_lat),
        .oce (a_rd_oce),
        .q   (a_rd_data)
    );

endmodule
